// File: rtl/div_unit.sv
// div_unit: 32-bit signed/unsigned restoring divider, one quotient bit per cycle,
// result {remainder, quotient} held until the requester drops start_i.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o
);
    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;
    state_t state, state_next;
    logic [64:0] w;
    logic [31:0] divisor, op1_mag, op2_mag, quo_fix, rem_fix;
    logic [32:0] trial;
    logic [5:0]  cnt;
    logic        neg_q, neg_r, go;
    assign go      = start_i && !annul_i;
    assign op1_mag = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    assign op2_mag = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    assign trial   = {1'b0, w[63:32]} - {1'b0, divisor};
    assign quo_fix = neg_q ? -w[31:0] : w[31:0];
    assign rem_fix = neg_r ? -w[64:33] : w[64:33];
    always_comb begin
        state_next = state;
        case (state)
            FREE:    state_next = go ? ((opdata2_i == 32'd0) ? BY_ZERO : ON) : FREE;
            BY_ZERO: state_next = END;
            ON:      state_next = annul_i ? FREE : ((cnt == 6'd32) ? END : ON);
            END:     state_next = start_i ? END : FREE;
            default: state_next = FREE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= FREE;
        else     state <= state_next;
    end
    // Working register holds {partial remainder, dividend/quotient bits, spare}.
    always_ff @(posedge clk) begin
        if (rst) begin
            w        <= '0;
            divisor  <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (go && opdata2_i != 32'd0) begin
                        cnt     <= '0;
                        w       <= {32'b0, op1_mag, 1'b0};
                        divisor <= op2_mag;
                        neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_r   <= signed_div_i & opdata1_i[31];
                    end
                end
                BY_ZERO: begin
                    ready_o  <= 1'b1;
                    result_o <= '0;
                end
                ON: begin
                    if (annul_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else if (cnt == 6'd32) begin
                        ready_o  <= 1'b1;
                        result_o <= {rem_fix, quo_fix};
                    end else begin
                        cnt <= cnt + 6'd1;
                        w   <= trial[32] ? {w[63:0], 1'b0} : {trial[31:0], w[31:0], 1'b1};
                    end
                end
                END: begin
                    if (!start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random checks of div_unit, results tracked through
// an expected-value queue popped when ready_o rises.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst, start_i, annul_i, signed_div_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic [63:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;

    div_unit dut (
        .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
        .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (sg) return {32'(sa % sb), 32'(sa / sb)};
        return {a % b, a / b};
    endfunction

    // Leaves start_i high and the unit in END when it returns.
    task automatic run(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat, input logic scramble);
        int n;
        logic [63:0] e;
        exp_q.push_back(exp);
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
            if (n == 1 && scramble) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~sg;
            end
        end while (!ready_o && n < 100);
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        e = exp_q.pop_front();
        chk({tag, "_result"}, result_o, e);
    endtask

    task automatic release_chk(input string tag);
        start_i = 1'b0;
        cyc();
        chk({tag, "_rel_ready"}, 64'(ready_o), 64'd0);
        chk({tag, "_rel_result"}, result_o, 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        cyc();
        chk("idle_ready", 64'(ready_o), 64'd0);

        run("udiv_7_2", 1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 34, 1'b0);
        release_chk("udiv_7_2");

        run("sdiv_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, 1'b1);
        release_chk("sdiv_m7_2");

        run("div_zero", 1'b0, 32'h12345678, 32'd0, 64'h0, 2, 1'b0);
        chk("div_zero_ready", 64'(ready_o), 64'd1);
        release_chk("div_zero");

        signed_div_i = 1'b0; opdata1_i = 32'h12345678; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (11) begin
            cyc();
            chk("annul_no_ready", 64'(ready_o), 64'd0);
        end
        annul_i = 1'b1; start_i = 1'b0;
        cyc();
        annul_i = 1'b0;
        chk("annul_ready", 64'(ready_o), 64'd0);
        chk("annul_result", result_o, 64'd0);
        repeat (3) begin
            cyc();
            chk("annul_idle_ready", 64'(ready_o), 64'd0);
        end
        run("udiv_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 1'b0);
        release_chk("udiv_100_7");

        run("sdiv_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 1'b0);
        held = result_o;
        repeat (5) begin
            cyc();
            chk("ovf_hold_ready", 64'(ready_o), 64'd1);
            chk("ovf_hold_result", result_o, held);
        end
        annul_i = 1'b1;
        cyc();
        annul_i = 1'b0;
        chk("end_annul_ready", 64'(ready_o), 64'd1);
        chk("end_annul_result", result_o, 64'h00000000_80000000);
        release_chk("sdiv_ovf");

        signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
        start_i = 1'b1; annul_i = 1'b1;
        repeat (3) begin
            cyc();
            chk("start_annul_ready", 64'(ready_o), 64'd0);
        end
        annul_i = 1'b0;
        run("udiv_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, 1'b0);
        release_chk("udiv_9_3");

        signed_div_i = 1'b0; opdata1_i = 32'h55555555; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (21) cyc();
        rst = 1'b1; start_i = 1'b0;
        cyc();
        rst = 1'b0;
        chk("rst_mid_ready", 64'(ready_o), 64'd0);
        chk("rst_mid_result", result_o, 64'd0);
        run("udiv_ff_10", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 34, 1'b0);
        release_chk("udiv_ff_10");

        for (int i = 0; i < 8; i++) begin
            logic        sg;
            logic [31:0] a, b;
            sg = 1'(i);
            a  = $urandom;
            b  = (i < 4) ? $urandom : 32'($urandom_range(1, 1000));
            if (b == 0) b = 32'd1;
            if (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd2;
            if (i == 7) a = 32'h80000000 | a;
            run("random", sg, a, b, model(sg, a, b), 34, 1'b1);
            release_chk("random");
        end

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
